// File: rtl/pipe_column_gen_pkg.sv
// pipe_pkg: shared state encoding and LFSR definition for the pipe column generator
package pipe_pkg;

    typedef enum logic [1:0] {IDLE, PIPE, SPACE} pipe_state_t;

    localparam int                LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; a stuck all-zero register is kicked back to 1
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return (l == '0) ? LFSR_W'(1) : {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pipe_column_gen_gap_mask.sv
// pipe_gap_mask: turns a random width/offset pair into an on-screen gap and its wall mask
module pipe_gap_mask
    import pipe_pkg::*;
#(
    parameter int ROWS           = 16,
    parameter int GAP_BASE       = 3,
    parameter int GAP_BASE_WIDTH = 2,
    parameter int GAP_VAR_BITS   = 2
) (
    input  logic [GAP_VAR_BITS-1:0] w,
    input  logic [GAP_VAR_BITS-1:0] o,
    output logic [ROWS-1:0]         mask,
    output logic [$clog2(ROWS)-1:0] gap_lo,
    output logic [$clog2(ROWS)-1:0] gap_hi
);

    localparam int LW = $clog2(ROWS);

    int h;
    int off;
    int lo;
    int hi;

    // Pull the offset down so the gap never runs off the top, then clear the gap rows
    always_comb begin
        h      = GAP_BASE_WIDTH + int'(w);
        off    = int'(o);
        off    = (GAP_BASE + off + h > ROWS) ? ROWS - GAP_BASE - h : off;
        off    = (off < 0) ? 0 : off;
        lo     = GAP_BASE + off;
        hi     = lo + h - 1;
        mask   = '0;
        for (int i = 0; i < ROWS; i++) mask[i] = !(i >= lo && i <= hi);
        gap_lo = LW'(lo);
        gap_hi = LW'(hi);
    end

endmodule

// File: rtl/pipe_column_gen.sv
// pipe_column_gen: streams wall/gap columns for the scrolling pipe field over ready/valid
module pipe_column_gen
    import pipe_pkg::*;
#(
    parameter int                ROWS           = 16,
    parameter int                GAP_BASE       = 3,
    parameter int                GAP_BASE_WIDTH = 2,
    parameter int                GAP_VAR_BITS   = 2,
    parameter int                PIPE_THICK     = 2,
    parameter int                SPACE_COLS     = 6,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    col_ready,
    output logic                    col_valid,
    output logic [ROWS-1:0]         col_out,
    output logic [$clog2(ROWS)-1:0] gap_lo,
    output logic [$clog2(ROWS)-1:0] gap_hi,
    output logic                    pipe_passed
);

    localparam int LW = $clog2(ROWS);
    localparam int CW = $clog2((PIPE_THICK > SPACE_COLS ? PIPE_THICK : SPACE_COLS) + 1);

    pipe_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              col_valid_q, col_valid_d;
    logic [ROWS-1:0]   col_out_q, col_out_d;
    logic [LW-1:0]     gap_lo_q, gap_lo_d;
    logic [LW-1:0]     gap_hi_q, gap_hi_d;
    logic              pipe_passed_q, pipe_passed_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [ROWS-1:0]   mask;
    logic [LW-1:0]     m_lo;
    logic [LW-1:0]     m_hi;
    logic              xfer;

    pipe_gap_mask #(
        .ROWS          (ROWS),
        .GAP_BASE      (GAP_BASE),
        .GAP_BASE_WIDTH(GAP_BASE_WIDTH),
        .GAP_VAR_BITS  (GAP_VAR_BITS)
    ) u_mask (
        .w     (lfsr_q[GAP_VAR_BITS-1:0]),
        .o     (lfsr_q[2*GAP_VAR_BITS-1:GAP_VAR_BITS]),
        .mask  (mask),
        .gap_lo(m_lo),
        .gap_hi(m_hi)
    );

    assign xfer = col_valid_q & col_ready;

    // Next column: everything holds unless a transfer moves the pattern along; clear wins
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        col_valid_d   = col_valid_q;
        col_out_d     = col_out_q;
        gap_lo_d      = gap_lo_q;
        gap_hi_d      = gap_hi_q;
        pipe_passed_d = 1'b0;
        lfsr_d        = lfsr_next(lfsr_q);
        if (clear) begin
            state_d     = IDLE;
            col_valid_d = 1'b0;
            col_out_d   = '0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d     = PIPE;
                    cnt_d       = '0;
                    col_valid_d = 1'b1;
                    col_out_d   = mask;
                    gap_lo_d    = m_lo;
                    gap_hi_d    = m_hi;
                end
                PIPE: if (xfer) begin
                    if (cnt_q == CW'(PIPE_THICK - 1)) begin
                        state_d       = SPACE;
                        cnt_d         = '0;
                        col_out_d     = '0;
                        pipe_passed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SPACE: if (xfer) begin
                    if (cnt_q == CW'(SPACE_COLS - 1)) begin
                        state_d   = PIPE;
                        cnt_d     = '0;
                        col_out_d = mask;
                        gap_lo_d  = m_lo;
                        gap_hi_d  = m_hi;
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                        col_out_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, cleared the instant reset_n drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            col_valid_q   <= 1'b0;
            col_out_q     <= '0;
            gap_lo_q      <= '0;
            gap_hi_q      <= '0;
            pipe_passed_q <= 1'b0;
            lfsr_q        <= LFSR_SEED;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_valid_q   <= col_valid_d;
            col_out_q     <= col_out_d;
            gap_lo_q      <= gap_lo_d;
            gap_hi_q      <= gap_hi_d;
            pipe_passed_q <= pipe_passed_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign col_valid   = col_valid_q;
    assign col_out     = col_out_q;
    assign gap_lo      = gap_lo_q;
    assign gap_hi      = gap_hi_q;
    assign pipe_passed = pipe_passed_q;

endmodule

// File: tb/tb_pipe_column_gen.sv
// tb_pipe_column_gen: scoreboard bench for the pipe column generator and its gap mask builder
module tb_pipe_column_gen;

    localparam int         ROWS = 16;
    localparam int         PT   = 2;
    localparam int         SC   = 3;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        col_ready = 1'b0;
    logic        col_valid;
    logic        pipe_passed;
    logic [15:0] col_out;
    logic [3:0]  gap_lo;
    logic [3:0]  gap_hi;

    logic [1:0]  mw = 2'd0;
    logic [1:0]  mo = 2'd0;
    logic [15:0] m16;
    logic [3:0]  m16_lo;
    logic [3:0]  m16_hi;
    logic [7:0]  m8;
    logic [2:0]  m8_lo;
    logic [2:0]  m8_hi;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_column_gen #(
        .ROWS(ROWS), .GAP_BASE(3), .GAP_BASE_WIDTH(2), .GAP_VAR_BITS(2),
        .PIPE_THICK(PT), .SPACE_COLS(SC), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clear(clear), .col_ready(col_ready),
        .col_valid(col_valid), .col_out(col_out), .gap_lo(gap_lo), .gap_hi(gap_hi),
        .pipe_passed(pipe_passed)
    );

    pipe_gap_mask #(.ROWS(16), .GAP_BASE(3), .GAP_BASE_WIDTH(2), .GAP_VAR_BITS(2)) u_m16 (
        .w(mw), .o(mo), .mask(m16), .gap_lo(m16_lo), .gap_hi(m16_hi)
    );

    pipe_gap_mask #(.ROWS(8), .GAP_BASE(3), .GAP_BASE_WIDTH(2), .GAP_VAR_BITS(2)) u_m8 (
        .w(mw), .o(mo), .mask(m8), .gap_lo(m8_lo), .gap_hi(m8_hi)
    );

    typedef struct packed {
        logic [15:0] col;
        logic [3:0]  lo;
        logic [3:0]  hi;
    } exp_t;

    exp_t       exp_q[$];
    logic       exp_valid = 1'b0;
    logic       exp_pp = 1'b0;
    logic [7:0] mlfsr = SEED;
    logic [7:0] rec_q[$];
    logic [7:0] rec_a[$];

    // Gap geometry straight from the rules: height 2+w from row 3+o, pulled down to fit
    function automatic exp_t gap_of(input int rows, input int w, input int o);
        exp_t e;
        int   h;
        h = 2 + w;
        if (3 + o + h > rows) o = rows - 3 - h;
        if (o < 0) o = 0;
        e.lo  = 4'(3 + o);
        e.hi  = 4'(3 + o + h - 1);
        e.col = 16'(((1 << rows) - 1) & ~(((1 << h) - 1) << (3 + o)));
        return e;
    endfunction

    // Polynomial x^8+x^6+x^5+x^4+1 as a parity of the tapped bits shifted in at the bottom
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        if (l == 8'h00) return 8'h01;
        return 8'(((l << 1) | ($countones(l & 8'hB8) % 2)) & 8'hFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks position within the wall/space period and queues each column to come
    initial begin
        int   mpos;
        bit   mact;
        exp_t cur;
        exp_t e;
        mpos = 0;
        mact = 0;
        cur  = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mact = 0;
                mpos = 0;
                exp_valid = 1'b0;
                exp_pp = 1'b0;
                mlfsr = SEED;
                exp_q.delete();
            end else begin
                exp_pp = 1'b0;
                if (clear) begin
                    mact = 0;
                    exp_valid = 1'b0;
                    exp_q.delete();
                end else if (!mact) begin
                    if (start) begin
                        cur = gap_of(ROWS, int'(mlfsr % 4), int'((mlfsr / 4) % 4));
                        mact = 1;
                        mpos = 0;
                        exp_valid = 1'b1;
                        exp_q.push_back(cur);
                    end
                end else if (col_ready) begin
                    mpos = (mpos + 1) % (PT + SC);
                    if (mpos == PT) exp_pp = 1'b1;
                    if (mpos == 0) cur = gap_of(ROWS, int'(mlfsr % 4), int'((mlfsr / 4) % 4));
                    e = cur;
                    if (mpos >= PT) e.col = 16'h0000;
                    exp_q.push_back(e);
                end
                mlfsr = lfsr_step(mlfsr);
            end
        end
    end

    // Monitor: every presented column must match the head of the queue until it is accepted
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            chk("col_valid", 32'(col_valid), 32'(exp_valid));
            chk("pipe_passed", 32'(pipe_passed), 32'(exp_pp));
            if (pipe_passed) rec_q.push_back({gap_lo, gap_hi});
            if (col_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: column %0h presented, none expected", col_out);
                end else begin
                    chk("col_out", 32'(col_out), 32'(exp_q[0].col));
                    chk("gap_lo", 32'(gap_lo), 32'(exp_q[0].lo));
                    chk("gap_hi", 32'(gap_hi), 32'(exp_q[0].hi));
                    if (col_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        exp_t e;
        exp_t e8;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        col_ready = 1'b1;
        // run A: free-flowing stream from a fixed start cycle
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rec_a = rec_q;
        rec_q.delete();
        chk("run_a_pipes", 32'(rec_a.size() >= 5), 32'd1);
        // asynchronous reset while inside the space run
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pipe_passed && n < 20);
        chk("wait_space", 32'(pipe_passed), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(col_valid), 32'd0);
        chk("rst_col", 32'(col_out), 32'h0000);
        chk("rst_pp", 32'(pipe_passed), 32'd0);
        chk("rst_lo", 32'(gap_lo), 32'd0);
        chk("rst_hi", 32'(gap_hi), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", 32'(col_valid), 32'd0);
        chk("rst_hold_col", 32'(col_out), 32'h0000);
        @(posedge clk);
        #1 reset_n = 1'b1;
        // run B: identical timing must reproduce run A's gaps
        rec_q.delete();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("run_b_len", 32'(rec_q.size()), 32'(rec_a.size()));
        for (int i = 0; i < rec_a.size() && i < rec_q.size(); i++) chk("run_b_gap", 32'(rec_q[i]), 32'(rec_a[i]));
        // clear and start together while a wall column is out
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(col_valid && col_out != 16'h0000) && n < 20);
        chk("wait_pipe", 32'(col_valid && col_out != 16'h0000), 32'd1);
        clear = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("clear_wins", 32'(col_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("restart", 32'(col_valid), 32'd1);
        // backpressure on the first wall column
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        col_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 col_ready = 1'b1;
        repeat (10) @(posedge clk);
        // random traffic
        repeat (400) begin
            @(posedge clk);
            #1;
            col_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 40) == 0);
        end
        #0;
        clear = 1'b0;
        start = 1'b0;
        col_ready = 1'b1;
        repeat (10) @(posedge clk);
        // mask builder on its own
        mw = 2'd0;
        mo = 2'd0;
        #1;
        chk("mask_00", 32'(m16), 32'hFFE7);
        chk("mask_00_lo", 32'(m16_lo), 32'd3);
        chk("mask_00_hi", 32'(m16_hi), 32'd4);
        mw = 2'd3;
        mo = 2'd3;
        #1;
        chk("mask_33", 32'(m16), 32'hF83F);
        chk("mask_33_lo", 32'(m16_lo), 32'd6);
        chk("mask_33_hi", 32'(m16_hi), 32'd10);
        chk("mask8_33", 32'(m8), 32'h07);
        chk("mask8_33_lo", 32'(m8_lo), 32'd3);
        chk("mask8_33_hi", 32'(m8_hi), 32'd7);
        for (int w = 0; w < 4; w++) begin
            for (int o = 0; o < 4; o++) begin
                mw = 2'(w);
                mo = 2'(o);
                #1;
                e  = gap_of(16, w, o);
                e8 = gap_of(8, w, o);
                chk("mask16_sweep", 32'(m16), 32'(e.col));
                chk("mask16_sweep_lo", 32'(m16_lo), 32'(e.lo));
                chk("mask8_sweep", 32'(m8), 32'(e8.col[7:0]));
                chk("mask8_sweep_hi", 32'(m8_hi), 32'(e8.hi[2:0]));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
